// File: rtl/jtframe_ram_nslot_arb_if.sv
// Bundle of the slot-side request bus and the SDRAM controller handshake.
// The arbiter connects through 'master'; requesters and the controller model use 'slave'.
interface jtframe_ram_nslot_arb_if #(
    parameter int SDRAMW = 22,
    parameter int NSLOT  = 5
);
    logic [NSLOT-1:0]        slot_req;
    logic [NSLOT-1:0]        slot_rnw;
    logic [NSLOT*SDRAMW-1:0] slot_addr;
    logic [NSLOT*16-1:0]     slot_din;
    logic [NSLOT*2-1:0]      slot_wrmask;
    logic [NSLOT-1:0]        slot_sel;
    logic                    sdram_ack;
    logic                    data_rdy;
    logic                    sdram_rd;
    logic                    sdram_wr;
    logic [SDRAMW-1:0]       sdram_addr;
    logic [15:0]             data_write;
    logic [1:0]              sdram_wrmask;
    logic                    busy;
    logic                    tout_err;

    modport master (
        input  slot_req, slot_rnw, slot_addr, slot_din, slot_wrmask, sdram_ack, data_rdy,
        output slot_sel, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask, busy, tout_err
    );

    modport slave (
        output slot_req, slot_rnw, slot_addr, slot_din, slot_wrmask, sdram_ack, data_rdy,
        input  slot_sel, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask, busy, tout_err
    );
endinterface

// File: rtl/jtframe_ram_nslot_arb.sv
// N-slot SDRAM arbiter: fixed or round-robin priority with starvation aging,
// back-to-back re-grant on completion and a data-return watchdog.
module jtframe_ram_nslot_arb #(
    parameter int SDRAMW  = 22,
    parameter int NSLOT   = 5,
    parameter int WRMASK  = 1,
    parameter int RR      = 0,
    parameter int MAXWAIT = 0,
    parameter int TOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    jtframe_ram_nslot_arb_if.master   bus
);
    localparam int IW = $clog2(NSLOT);
    localparam int AW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;
    localparam int TW = ($clog2(TOUT + 1) > 8) ? $clog2(TOUT + 1) : 8;
    localparam logic [15:0]   WRM     = 16'(WRMASK);
    localparam logic [AW-1:0] AGE_MAX = AW'(MAXWAIT);
    localparam logic [TW-1:0] WD_LAST = TW'((TOUT > 0) ? TOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [NSLOT-1:0]  sel_q, sel_d;
    logic              rd_q, rd_d, wr_q, wr_d, tout_q, tout_d;
    logic [SDRAMW-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic [1:0]        mask_q, mask_d;
    logic [IW-1:0]     last_q, last_d;
    logic [TW-1:0]     wd_q, wd_d;
    logic [AW-1:0]     age_q [NSLOT];
    logic [AW-1:0]     age_d [NSLOT];

    logic [SDRAMW-1:0] addr_a [NSLOT];
    logic [15:0]       din_a  [NSLOT];
    logic [1:0]        mask_a [NSLOT];

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        assign addr_a[gi] = bus.slot_addr[gi*SDRAMW +: SDRAMW];
        assign din_a[gi]  = bus.slot_din[gi*16 +: 16];
        assign mask_a[gi] = bus.slot_wrmask[gi*2 +: 2];
    end

    // The slot being served still holds slot_sel, so it never competes for its own re-grant.
    logic [NSLOT-1:0] active;
    assign active = bus.slot_req & ~sel_q;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          win_rd;

    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        if (MAXWAIT > 0) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (!win_found && active[i] && age_q[i] == AGE_MAX) begin
                    win_found = 1'b1;
                    win_idx   = IW'(i);
                end
            end
        end
        if (!win_found) begin
            if (RR == 0) begin
                for (int i = 0; i < NSLOT; i++) begin
                    if (!win_found && active[i]) begin
                        win_found = 1'b1;
                        win_idx   = IW'(i);
                    end
                end
            end else begin
                for (int k = 1; k <= NSLOT; k++) begin
                    j = int'(last_q) + k;
                    if (j >= NSLOT) j = j - NSLOT;
                    if (!win_found && active[j]) begin
                        win_found = 1'b1;
                        win_idx   = IW'(j);
                    end
                end
            end
        end
        // Slots without write permission are always issued as reads.
        win_rd = bus.slot_rnw[win_idx] | ~WRM[win_idx];
    end

    always_comb begin
        logic grant;
        grant   = 1'b0;
        state_d = state_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        mask_d  = mask_q;
        last_d  = last_q;
        wd_d    = wd_q;
        tout_d  = 1'b0;
        age_d   = age_q;

        case (state_q)
            S_IDLE: grant = |active;
            S_REQ: begin
                if (bus.sdram_ack) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (bus.data_rdy) begin
                        sel_d = '0;
                        if (|active) grant = 1'b1;
                        else         state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        wd_d    = '0;
                    end
                end
            end
            S_WAIT: begin
                if (bus.data_rdy) begin
                    sel_d = '0;
                    if (|active) grant = 1'b1;
                    else         state_d = S_IDLE;
                end else if (TOUT > 0) begin
                    if (wd_q == WD_LAST) begin
                        tout_d  = 1'b1;
                        sel_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant) begin
            state_d = S_REQ;
            sel_d   = NSLOT'(1) << win_idx;
            addr_d  = addr_a[win_idx];
            dout_d  = din_a[win_idx];
            rd_d    = win_rd;
            wr_d    = ~win_rd;
            mask_d  = win_rd ? 2'b11 : mask_a[win_idx];
            if (RR != 0) last_d = win_idx;
            if (MAXWAIT > 0) begin
                for (int i = 0; i < NSLOT; i++) begin
                    if (IW'(i) == win_idx)                   age_d[i] = '0;
                    else if (active[i] && age_q[i] < AGE_MAX) age_d[i] = age_q[i] + 1'b1;
                end
            end
        end

        if (MAXWAIT > 0) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (!bus.slot_req[i]) age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            mask_q  <= 2'b11;
            tout_q  <= 1'b0;
            last_q  <= IW'(NSLOT - 1);
            wd_q    <= '0;
            for (int i = 0; i < NSLOT; i++) age_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            mask_q  <= mask_d;
            tout_q  <= tout_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            age_q   <= age_d;
        end
    end

    assign bus.slot_sel     = sel_q;
    assign bus.sdram_rd     = rd_q;
    assign bus.sdram_wr     = wr_q;
    assign bus.sdram_addr   = addr_q;
    assign bus.data_write   = dout_q;
    assign bus.sdram_wrmask = mask_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.tout_err     = tout_q;
endmodule

// File: tb/tb_jtframe_ram_nslot_arb.sv
// Two arbiter configurations (fixed+aging+short watchdog, round-robin+aging) checked
// cycle by cycle against a transaction-level model, plus directed literal checks.
module tb_jtframe_ram_nslot_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  req [2];
    logic [4:0]  rnw [2];
    logic [21:0] addr [2][5];
    logic [15:0] din [2][5];
    logic [1:0]  wm [2][5];
    logic        ack [2];
    logic        rdy [2];
    bit          auto_en [2];
    logic [4:0]  donep [2];
    bit          cmp_en = 1'b1;
    int          checks = 0;
    int          errors = 0;

    jtframe_ram_nslot_arb_if #(.SDRAMW(22), .NSLOT(5)) ifa ();
    jtframe_ram_nslot_arb_if #(.SDRAMW(22), .NSLOT(4)) ifb ();

    jtframe_ram_nslot_arb #(.SDRAMW(22), .NSLOT(5), .WRMASK(1), .RR(0), .MAXWAIT(2), .TOUT(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    jtframe_ram_nslot_arb #(.SDRAMW(22), .NSLOT(4), .WRMASK(15), .RR(1), .MAXWAIT(3), .TOUT(20))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    always_comb begin
        ifa.slot_req  = req[0];
        ifa.slot_rnw  = rnw[0];
        ifa.sdram_ack = ack[0];
        ifa.data_rdy  = rdy[0];
        ifb.slot_req  = req[1][3:0];
        ifb.slot_rnw  = rnw[1][3:0];
        ifb.sdram_ack = ack[1];
        ifb.data_rdy  = rdy[1];
        ifa.slot_addr = {addr[0][4], addr[0][3], addr[0][2], addr[0][1], addr[0][0]};
        ifa.slot_din  = {din[0][4], din[0][3], din[0][2], din[0][1], din[0][0]};
        ifa.slot_wrmask = {wm[0][4], wm[0][3], wm[0][2], wm[0][1], wm[0][0]};
        ifb.slot_addr = {addr[1][3], addr[1][2], addr[1][1], addr[1][0]};
        ifb.slot_din  = {din[1][3], din[1][2], din[1][1], din[1][0]};
        ifb.slot_wrmask = {wm[1][3], wm[1][2], wm[1][1], wm[1][0]};
    end

    function automatic int ns(int d);  return (d == 0) ? 5 : 4;  endfunction
    function automatic int rr(int d);  return (d == 0) ? 0 : 1;  endfunction
    function automatic int mw(int d);  return (d == 0) ? 2 : 3;  endfunction
    function automatic int wmk(int d); return (d == 0) ? 1 : 15; endfunction
    function automatic int to(int d);  return (d == 0) ? 8 : 20; endfunction

    // Model: phase 0 idle, 1 command pending, 2 waiting for data; owner -1 = none.
    int          m_ph [2], m_own [2], m_last [2], m_wd [2];
    int          m_age [2][5];
    logic        m_rd [2], m_wr [2], m_tout [2];
    logic [21:0] m_addr [2];
    logic [15:0] m_dout [2];
    logic [1:0]  m_mask [2];

    function automatic void model_reset(int d);
        m_ph[d] = 0; m_own[d] = -1; m_last[d] = ns(d) - 1; m_wd[d] = 0;
        m_rd[d] = 1'b0; m_wr[d] = 1'b0; m_tout[d] = 1'b0;
        m_addr[d] = '0; m_dout[d] = '0; m_mask[d] = 2'b11;
        for (int i = 0; i < 5; i++) m_age[d][i] = 0;
    endfunction

    function automatic int pick(int d, logic [4:0] act);
        for (int i = 0; i < ns(d); i++)
            if (mw(d) > 0 && act[i] && m_age[d][i] == mw(d)) return i;
        if (rr(d) == 0) begin
            for (int i = 0; i < ns(d); i++) if (act[i]) return i;
        end else begin
            for (int k = 1; k <= ns(d); k++) if (act[(m_last[d] + k) % ns(d)]) return (m_last[d] + k) % ns(d);
        end
        return -1;
    endfunction

    function automatic void model_step(int d);
        logic [4:0] act, own_b;
        int w;
        bit g;
        if (rst) begin model_reset(d); return; end
        own_b = (m_own[d] < 0) ? 5'd0 : 5'(1 << m_own[d]);
        act = req[d] & ~own_b;
        m_tout[d] = 1'b0;
        g = 1'b0;
        case (m_ph[d])
            0: g = |act;
            1: if (ack[d]) begin
                   m_rd[d] = 1'b0; m_wr[d] = 1'b0;
                   if (rdy[d]) begin m_own[d] = -1; if (|act) g = 1'b1; else m_ph[d] = 0; end
                   else begin m_ph[d] = 2; m_wd[d] = 0; end
               end
            default:
               if (rdy[d]) begin m_own[d] = -1; if (|act) g = 1'b1; else m_ph[d] = 0; end
               else if (to(d) > 0) begin
                   m_wd[d]++;
                   if (m_wd[d] == to(d)) begin m_tout[d] = 1'b1; m_own[d] = -1; m_ph[d] = 0; end
               end
        endcase
        if (g) begin
            w = pick(d, act);
            m_own[d] = w; m_ph[d] = 1; m_last[d] = w;
            m_addr[d] = addr[d][w]; m_dout[d] = din[d][w];
            m_rd[d] = rnw[d][w] || (((wmk(d) >> w) & 1) == 0);
            m_wr[d] = !m_rd[d];
            m_mask[d] = m_rd[d] ? 2'b11 : wm[d][w];
            for (int i = 0; i < ns(d); i++) begin
                if (i == w) m_age[d][i] = 0;
                else if (act[i] && m_age[d][i] < mw(d)) m_age[d][i]++;
            end
            $display("txn dut%0d slot %0d %s addr %h", d, w, m_rd[d] ? "rd" : "wr", m_addr[d]);
        end
        for (int i = 0; i < ns(d); i++) if (!req[d][i]) m_age[d][i] = 0;
    endfunction

    initial begin model_reset(0); model_reset(1); end

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    function automatic logic [48:0] expv(int d);
        logic [4:0] s;
        s = (m_own[d] < 0) ? 5'd0 : 5'(1 << m_own[d]);
        return {s, m_rd[d], m_wr[d], m_addr[d], m_dout[d], m_mask[d], m_ph[d] != 0, m_tout[d]};
    endfunction

    task automatic cmp(int d, logic [48:0] got);
        checks++;
        if (got !== expv(d)) begin
            errors++;
            $display("FAIL cycle_dut%0d t=%0t got %h want %h (sel,rd,wr,addr,dout,mask,busy,tout)",
                     d, $time, got, expv(d));
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, {ifa.slot_sel, ifa.sdram_rd, ifa.sdram_wr, ifa.sdram_addr, ifa.data_write,
                    ifa.sdram_wrmask, ifa.busy, ifa.tout_err});
            cmp(1, {1'b0, ifb.slot_sel, ifb.sdram_rd, ifb.sdram_wr, ifb.sdram_addr, ifb.data_write,
                    ifb.sdram_wrmask, ifb.busy, ifb.tout_err});
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic rand_fields(int d, int i);
        rnw[d][i]  = 1'($urandom_range(0, 1));
        addr[d][i] = 22'($urandom);
        din[d][i]  = 16'($urandom);
        wm[d][i]   = 2'($urandom);
    endtask

    task automatic do_auto(int d);
        for (int i = 0; i < ns(d); i++) begin
            if (donep[d][i]) begin
                donep[d][i] = 1'b0;
                if ($urandom_range(0, 1) == 0) req[d][i] = 1'b0;
                else rand_fields(d, i);
            end else if (!req[d][i] && $urandom_range(0, 3) == 0) begin
                req[d][i] = 1'b1;
                rand_fields(d, i);
            end
        end
        ack[d] = (m_ph[d] == 1) && ($urandom_range(0, 1) == 1);
        if (m_ph[d] == 2)                 rdy[d] = ($urandom_range(0, 9) < 4);
        else if (m_ph[d] == 1 && ack[d])  rdy[d] = ($urandom_range(0, 4) == 0);
        else if (m_ph[d] == 0)            rdy[d] = ($urandom_range(0, 19) == 0);
        else                              rdy[d] = 1'b0;
        if (rdy[d] && m_own[d] >= 0 && (m_ph[d] == 2 || (m_ph[d] == 1 && ack[d])))
            donep[d][m_own[d]] = 1'b1;
    endtask

    // Inputs change at negedge+2; the edge then happens and outputs are compared at the next negedge.
    task automatic tick();
        for (int d = 0; d < 2; d++) if (auto_en[d]) do_auto(d);
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic set_slot(int d, int i, logic r, logic rn, logic [21:0] a, logic [15:0] dn, logic [1:0] m);
        req[d][i] = r; rnw[d][i] = rn; addr[d][i] = a; din[d][i] = dn; wm[d][i] = m;
    endtask

    logic [4:0] g0, g1, g2;
    int order [5];

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; rnw[d] = '0; ack[d] = 1'b0; rdy[d] = 1'b0; auto_en[d] = 1'b0; donep[d] = '0;
            for (int i = 0; i < 5; i++) set_slot(d, i, 1'b0, 1'b1, 22'h0, 16'h0, 2'b11);
        end
        tick();
        check("rst_sel", 32'(ifa.slot_sel), 32'h0);
        check("rst_mask", 32'(ifa.sdram_wrmask), 32'h3);
        check("rst_busy", 32'(ifa.busy), 32'h0);
        rst = 1'b0;
        tick();

        // Fixed priority: slot 1 before slot 3, slot 3 re-granted on the data_rdy edge.
        set_slot(0, 1, 1'b1, 1'b1, 22'h100, 16'h0, 2'b00);
        set_slot(0, 3, 1'b1, 1'b1, 22'h300, 16'h0, 2'b00);
        tick();
        check("t1_sel1", 32'(ifa.slot_sel), 32'h02);
        check("t1_rd", 32'(ifa.sdram_rd), 32'h1);
        check("t1_addr1", 32'(ifa.sdram_addr), 32'h100);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        check("t1_rd_drop", 32'(ifa.sdram_rd), 32'h0);
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        req[0][1] = 1'b0;
        check("t1_sel3", 32'(ifa.slot_sel), 32'h08);
        check("t1_addr3", 32'(ifa.sdram_addr), 32'h300);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        req[0][3] = 1'b0;
        check("t1_idle", 32'(ifa.busy), 32'h0);

        // Write permission: slot 0 may write, slot 2 is forced to read.
        set_slot(0, 0, 1'b1, 1'b0, 22'h050, 16'hBEEF, 2'b01);
        tick();
        check("t3_wr", 32'(ifa.sdram_wr), 32'h1);
        check("t3_dout", 32'(ifa.data_write), 32'hBEEF);
        check("t3_mask", 32'(ifa.sdram_wrmask), 32'h1);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        req[0][0] = 1'b0;
        set_slot(0, 2, 1'b1, 1'b0, 22'h222, 16'h1234, 2'b10);
        tick();
        check("t3_forced_rd", 32'({ifa.sdram_rd, ifa.sdram_wr}), 32'h2);
        check("t3_forced_mask", 32'(ifa.sdram_wrmask), 32'h3);
        ack[0] = 1'b1; rdy[0] = 1'b1; tick(); ack[0] = 1'b0; rdy[0] = 1'b0;
        req[0][2] = 1'b0;
        check("t3_ackrdy_idle", 32'(ifa.busy), 32'h0);

        // Aging: slots 0,1,4 held; without aging slot 0 would win the third grant.
        set_slot(0, 0, 1'b1, 1'b1, 22'h010, 16'h0, 2'b11);
        set_slot(0, 1, 1'b1, 1'b1, 22'h011, 16'h0, 2'b11);
        set_slot(0, 4, 1'b1, 1'b1, 22'h014, 16'h0, 2'b11);
        tick(); g0 = ifa.slot_sel;
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0; g1 = ifa.slot_sel;
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0; g2 = ifa.slot_sel;
        check("t4_g0", 32'(g0), 32'h01);
        check("t4_g1", 32'(g1), 32'h02);
        check("t4_g2_aged", 32'(g2), 32'h10);
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        req[0][4] = 1'b0;
        check("t4_idle", 32'(ifa.busy), 32'h0);

        // Watchdog: tout_err appears after the 8th edge in WAIT, for one cycle only.
        set_slot(0, 2, 1'b1, 1'b1, 22'h2AA, 16'h0, 2'b11);
        tick();
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        g0 = '0;
        for (int k = 1; k <= 7; k++) begin tick(); if (ifa.tout_err) g0 = g0 + 5'd1; end
        check("t5_early_tout", 32'(g0), 32'h0);
        tick();
        check("t5_tout", 32'({ifa.tout_err, ifa.busy, ifa.slot_sel}), 32'h40);
        req[0][2] = 1'b0; rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        check("t5_after", 32'({ifa.tout_err, ifa.busy, ifa.slot_sel}), 32'h0);

        // Reset during REQ abandons the command; a later ack does nothing.
        set_slot(0, 3, 1'b1, 1'b1, 22'h333, 16'h0, 2'b11);
        tick();
        check("t6_rd", 32'(ifa.sdram_rd), 32'h1);
        rst = 1'b1; req[0][3] = 1'b0; tick(); rst = 1'b0;
        check("t6_rst", 32'({ifa.sdram_rd, ifa.busy, ifa.slot_sel}), 32'h0);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        check("t6_ack_ignored", 32'({ifa.sdram_rd, ifa.busy, ifa.slot_sel}), 32'h0);

        // Round robin on the 4-slot instance with every slot requesting.
        for (int i = 0; i < 4; i++) set_slot(1, i, 1'b1, 1'b1, 22'(32'h40 + i), 16'h0, 2'b11);
        order = '{0, 1, 2, 3, 0};
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_rr_grant%0d", k), 32'(ifb.slot_sel), 32'(1 << order[k]));
            if (k == 4) req[1] = 5'b00001;
            ack[1] = 1'b1; tick(); ack[1] = 1'b0;
            rdy[1] = 1'b1; tick(); rdy[1] = 1'b0;
        end
        req[1] = '0;
        check("t2_idle", 32'(ifb.busy), 32'h0);

        // Randomised traffic on both instances, with occasional resets.
        donep[0] = '0; donep[1] = '0;
        auto_en[0] = 1'b1; auto_en[1] = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
